matmul_loader: RTL

MATMUL_LOADER -- requirements
Module: matmul_loader

---
 rtl/matmul_pkg.sv | 19 +
 rtl/mat_index_ctr.sv | 38 +++
 rtl/matmul_loader.sv | 85 ++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// matmul_pkg: shared constants and types for the matmul loader and datapath.
//   DATA_WIDTH - width of each signed input element
//   M          - square matrix dimension (operands are MxM)
//   ELEM_W     - accumulator-safe element width (2*DATA_WIDTH + clog2(M))
//   mat_elem   - signed element type fed to the matmul datapath
//   ld_state_e - loader FSM states
package matmul_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int M          = 32;
  localparam int ELEM_W     = 2*DATA_WIDTH + $clog2(M);

  typedef logic signed [ELEM_W-1:0] mat_elem;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    FULL   = 2'd2
  } ld_state_e;
endpackage

// File: rtl/mat_index_ctr.sv
// mat_index_ctr: row-major (row,col) position counter for an MxM buffer.
//   clk, reset - clock, async active-low reset (clears to (0,0))
//   adv        - advance one position; wraps (M-1,M-1) back to (0,0)
//   row, col   - current write position
//   last       - current position is (M-1,M-1)
module mat_index_ctr
  import matmul_pkg::*;
#(
  parameter int M  = matmul_pkg::M,
  parameter int RW = (M > 1) ? $clog2(M) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          adv,
  output logic [RW-1:0] row,
  output logic [RW-1:0] col,
  output logic          last
);
  localparam logic [RW-1:0] MAXI = RW'(M-1);

  assign last = (row == MAXI) && (col == MAXI);

  // The natural wrap at the last position is what clears the counters
  // between matrices, so the FSM never has to clear them explicitly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row <= '0;
      col <= '0;
    end else if (adv) begin
      if (col == MAXI) begin
        col <= '0;
        row <= (row == MAXI) ? '0 : row + RW'(1);
      end else begin
        col <= col + RW'(1);
      end
    end
  end
endmodule

// File: rtl/matmul_loader.sv
// matmul_loader: streams two MxM signed matrices (A then B, row-major) into
// operand buffers for the matmul datapath and holds them until consumed.
//   clk, reset   - clock, async active-low reset
//   in_valid/in_ready/in_data/in_last - element beat handshake; in_last marks
//                  the final element of each matrix
//   mat1, mat2   - operand A / B, sign-extended elements, [row][col]
//   mat_valid    - both operands complete and stable
//   mat_consume  - downstream has latched operands; return to loading A
//   err          - sticky framing error (in_last disagrees with position)
module matmul_loader
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = matmul_pkg::DATA_WIDTH,
  parameter int M          = matmul_pkg::M
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic                                                in_valid,
  output logic                                                in_ready,
  input  logic [DATA_WIDTH-1:0]                               in_data,
  input  logic                                                in_last,
  output logic [M-1:0][M-1:0][2*DATA_WIDTH+$clog2(M)-1:0]     mat1,
  output logic [M-1:0][M-1:0][2*DATA_WIDTH+$clog2(M)-1:0]     mat2,
  output logic                                                mat_valid,
  input  logic                                                mat_consume,
  output logic                                                err
);
  localparam int EW = 2*DATA_WIDTH + $clog2(M);
  localparam int RW = (M > 1) ? $clog2(M) : 1;

  ld_state_e       state, state_n;
  logic [RW-1:0]   row, col;
  logic            last;
  logic            xfer;
  logic [EW-1:0]   ext;

  assign xfer      = in_valid & in_ready;
  assign mat_valid = (state == FULL);
  assign ext       = {{(EW-DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};

  // One counter serves both buffers; the state picks which one is written.
  mat_index_ctr #(.M(M), .RW(RW)) u_ctr (
    .clk   (clk),
    .reset (reset),
    .adv   (xfer),
    .row   (row),
    .col   (col),
    .last  (last)
  );

  always_comb begin
    state_n = state;
    case (state)
      LOAD_A:  if (xfer && last) state_n = LOAD_B;
      LOAD_B:  if (xfer && last) state_n = FULL;
      FULL:    if (mat_consume)  state_n = LOAD_A;
      default: state_n = LOAD_A;
    endcase
  end

  // in_ready is registered from the next state so it tracks state exactly
  // without any combinational path from in_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= LOAD_A;
      in_ready <= 1'b1;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      in_ready <= (state_n != FULL);
      if (xfer && (in_last != last)) err <= 1'b1;
    end
  end

  // Transfers only happen while loading, so anything not LOAD_A is B.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mat1 <= '0;
      mat2 <= '0;
    end else if (xfer) begin
      if (state == LOAD_A) mat1[row][col] <= ext;
      else                 mat2[row][col] <= ext;
    end
  end
endmodule
